// File: rtl/frequency_regulator.sv
// frequency_regulator: steers a ring-oscillator divisor until the divided period lies in [fmax, fmin] clk cycles.
// Latency: ring_clk edge -> co 4 clk, -> co_passed_flipflop 5 clk, -> increment/decrement/adjusteddiv 6 clk.
// Backpressure: none; measurement is free-running and every output is a registered pulse or level.
// Option: FREQ_REG_LOCK_EN freezes the divisor after the first in-band measurement until init returns to 0.
module frequency_regulator (
  input  logic       clk_frequency,
  input  logic       rst_frequency,
  input  logic [7:0] fmax,
  input  logic [7:0] fmin,
  input  logic [7:0] setperiod,
  input  logic       ring_clk,
  input  logic       init,
  output logic       co,
  output logic       co_passed_flipflop,
  output logic       increment,
  output logic       decrement,
  output logic [7:0] final_sett,
  output logic [7:0] adjusteddiv
);

  logic       sync1;
  logic       sync2;
  logic       sync2_d;
  logic       ring_edge;
  logic       armed;
  logic       active;
  logic       first_done;
  logic [7:0] dcnt;
  logic [7:0] pcnt;
  logic [7:0] meas;
  logic [7:0] div_eff;
  logic       too_slow;
  logic       too_fast;
  logic       adjust_en;
  logic       hold;

  // The divider only runs once init has been seen low after reset, so a
  // zero divisor straight out of reset never clocks the loop.
  assign active    = init & armed;
  assign div_eff   = (adjusteddiv == 8'd0) ? 8'd1 : adjusteddiv;
  assign meas      = pcnt;
  assign too_slow  = (meas > fmin);
  assign too_fast  = (meas < fmax);
  assign adjust_en = active & co_passed_flipflop & first_done & ~hold;

`ifdef FREQ_REG_LOCK_EN
  logic locked;

  // Latch lock on the first in-band measurement; released only by idle.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      locked <= 1'b0;
    end else if (!init) begin
      locked <= 1'b0;
    end else if (adjust_en && !too_slow && !too_fast) begin
      locked <= 1'b1;
    end
  end

  assign hold = locked;
`else
  assign hold = 1'b0;
`endif

  // Two-flop synchroniser on the asynchronous oscillator, then a registered rising-edge detect.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync2_d   <= 1'b0;
      ring_edge <= 1'b0;
    end else begin
      sync1     <= ring_clk;
      sync2     <= sync1;
      sync2_d   <= sync2;
      ring_edge <= sync2 & ~sync2_d;
    end
  end

  // Arm the divider once init has been low for a cycle after reset.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      armed <= 1'b0;
    end else if (!init) begin
      armed <= 1'b1;
    end
  end

  // Divider: wraps on the divisor's terminal count. The >= guards against a
  // divisor that shrank below the running count.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      dcnt <= 8'd0;
      co   <= 1'b0;
    end else if (!active) begin
      dcnt <= 8'd0;
      co   <= 1'b0;
    end else if (ring_edge) begin
      if (dcnt >= div_eff - 8'd1) begin
        dcnt <= 8'd0;
        co   <= 1'b1;
      end else begin
        dcnt <= dcnt + 8'd1;
        co   <= 1'b0;
      end
    end else begin
      co <= 1'b0;
    end
  end

  // Measurement strobe is simply co one cycle later.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      co_passed_flipflop <= 1'b0;
    end else begin
      co_passed_flipflop <= co;
    end
  end

  // Period counter: saturating, restarted at 1 on each strobe so the next
  // strobe sees exactly the number of clk cycles between strobes.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      pcnt <= 8'd0;
    end else if (!active) begin
      pcnt <= 8'd0;
    end else if (co_passed_flipflop) begin
      pcnt <= 8'd1;
    end else if (pcnt != 8'hFF) begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // The first strobe after enabling has no preceding reference, so it only sets this flag.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      first_done <= 1'b0;
    end else if (!active) begin
      first_done <= 1'b0;
    end else if (co_passed_flipflop) begin
      first_done <= 1'b1;
    end
  end

  // Adjust rule: step the divisor toward the band, record it once in band.
  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      adjusteddiv <= 8'd0;
      final_sett  <= 8'd0;
      increment   <= 1'b0;
      decrement   <= 1'b0;
    end else begin
      increment <= 1'b0;
      decrement <= 1'b0;
      if (!init) begin
        adjusteddiv <= (setperiod == 8'd0) ? 8'd1 : setperiod;
      end else if (adjust_en) begin
        if (too_slow) begin
          decrement <= 1'b1;
          if (adjusteddiv > 8'd1) begin
            adjusteddiv <= adjusteddiv - 8'd1;
          end
        end else if (too_fast) begin
          increment <= 1'b1;
          if (adjusteddiv != 8'hFF) begin
            adjusteddiv <= adjusteddiv + 8'd1;
          end
        end else begin
          final_sett <= adjusteddiv;
        end
      end
    end
  end

endmodule

// File: tb/tb_frequency_regulator.sv
// Bench for frequency_regulator: directed scenarios with a pulse scoreboard.
module tb_frequency_regulator;

  logic       clk;
  logic       rst_n;
  logic [7:0] fmax;
  logic [7:0] fmin;
  logic [7:0] setperiod;
  logic       ring_clk;
  logic       init;
  logic       co;
  logic       co_passed_flipflop;
  logic       increment;
  logic       decrement;
  logic [7:0] final_sett;
  logic [7:0] adjusteddiv;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic [7:0] div;
  } ev_t;

  ev_t exp_q[$];

  logic ring_auto;
  logic ring_manual;
  logic ring_gen;
  int   ring_period;
  int   ring_cnt;
  logic co_prev;
  logic co_seen;

  frequency_regulator dut (
    .clk_frequency      (clk),
    .rst_frequency      (rst_n),
    .fmax               (fmax),
    .fmin               (fmin),
    .setperiod          (setperiod),
    .ring_clk           (ring_clk),
    .init               (init),
    .co                 (co),
    .co_passed_flipflop (co_passed_flipflop),
    .increment          (increment),
    .decrement          (decrement),
    .final_sett         (final_sett),
    .adjusteddiv        (adjusteddiv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: exact period in clk cycles, changed only at negedges.
  initial begin
    ring_gen = 1'b0;
    ring_cnt = 0;
  end
  always @(negedge clk) begin
    ring_cnt = (ring_cnt + 1 >= ring_period) ? 0 : ring_cnt + 1;
    ring_gen = (ring_cnt < ring_period / 2);
  end
  assign ring_clk = ring_auto ? ring_gen : ring_manual;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic inc, input logic dec, input int d);
    ev_t e;
    e.inc = inc;
    e.dec = dec;
    e.div = 8'(d);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still pending after %0d cycles, expected 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // Monitor: every adjust pulse must match the next expected event.
  initial co_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (increment || decrement) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({increment, decrement}), 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("pulse_inc", int'(increment), int'(e.inc));
          chk("pulse_dec", int'(decrement), int'(e.dec));
          chk("pulse_div", int'(adjusteddiv), int'(e.div));
        end
      end
      if (co_prev || co_passed_flipflop) begin
        chk("cpf_delay", int'(co_passed_flipflop), int'(co_prev));
      end
    end
    co_prev = co;
  end

  initial begin
    rst_n       = 1'b0;
    init        = 1'b1;
    setperiod   = 8'd0;
    fmax        = 8'd90;
    fmin        = 8'd160;
    ring_auto   = 1'b1;
    ring_manual = 1'b0;
    ring_period = 6;

    // Reset with init high and the oscillator running.
    tick(8);
    chk("rst_adjusteddiv", int'(adjusteddiv), 0);
    chk("rst_final_sett", int'(final_sett), 0);
    chk("rst_co", int'(co), 0);
    chk("rst_cpf", int'(co_passed_flipflop), 0);
    chk("rst_pulses", int'({increment, decrement}), 0);
    rst_n = 1'b1;
    co_seen = 1'b0;
    repeat (40) begin
      tick(1);
      if (co) co_seen = 1'b1;
    end
    chk("post_rst_no_co", int'(co_seen), 0);
    chk("post_rst_div", int'(adjusteddiv), 0);
    init = 1'b0;
    tick(1);
    chk("load_zero_as_one", int'(adjusteddiv), 1);

    // Pipeline latency with a single hand-driven oscillator edge, divisor 1.
    ring_auto   = 1'b0;
    ring_manual = 1'b0;
    setperiod   = 8'd1;
    tick(8);
    init = 1'b1;
    tick(8);
    ring_manual = 1'b1;
    tick(3);
    chk("lat_co_early", int'(co), 0);
    tick(1);
    chk("lat_co", int'(co), 1);
    chk("lat_cpf_early", int'(co_passed_flipflop), 0);
    tick(1);
    chk("lat_cpf", int'(co_passed_flipflop), 1);
    chk("lat_co_single", int'(co), 0);
    tick(4);
    ring_manual = 1'b0;
    init = 1'b0;

    // Slow-down: 6-clk oscillator, divisor 90 walks down to 26 (156 clk).
    setperiod   = 8'd90;
    fmax        = 8'd90;
    fmin        = 8'd160;
    ring_period = 6;
    ring_auto   = 1'b1;
    tick(4);
    chk("load_90", int'(adjusteddiv), 90);
    for (int d = 89; d >= 26; d--) push(1'b0, 1'b1, d);
    init = 1'b1;
    drain("slow_drain", 40000);
    tick(400);
    chk("slow_final_sett", int'(final_sett), 26);
    chk("slow_div", int'(adjusteddiv), 26);

    // Narrow the band so 156 clk is now too slow.
    fmin = 8'd100;
`ifdef FREQ_REG_LOCK_EN
    tick(1200);
    chk("lock_div_frozen", int'(adjusteddiv), 26);
    chk("lock_final_sett", int'(final_sett), 26);
`else
    for (int d = 25; d >= 16; d--) push(1'b0, 1'b1, d);
    drain("track_drain", 5000);
    tick(300);
    chk("track_final_sett", int'(final_sett), 16);
    chk("track_div", int'(adjusteddiv), 16);
`endif

    // Speed-up: 4-clk oscillator, divisor 10 climbs to 23 (92 clk).
    init        = 1'b0;
    setperiod   = 8'd10;
    fmin        = 8'd160;
    ring_period = 4;
    tick(4);
    chk("load_10", int'(adjusteddiv), 10);
    for (int d = 11; d <= 23; d++) push(1'b1, 1'b0, d);
    init = 1'b1;
    drain("fast_drain", 4000);
    tick(300);
    chk("fast_final_sett", int'(final_sett), 23);
    chk("fast_div", int'(adjusteddiv), 23);

    // Abort mid-measurement, then re-enable from 20 (80 clk, too fast).
    tick(30);
    init      = 1'b0;
    setperiod = 8'd20;
    tick(1);
    chk("abort_div", int'(adjusteddiv), 20);
    chk("abort_co", int'(co), 0);
    chk("abort_final_sett", int'(final_sett), 23);
    tick(4);
    for (int d = 21; d <= 23; d++) push(1'b1, 1'b0, d);
    init = 1'b1;
    drain("reenable_drain", 2000);
    tick(300);
    chk("reenable_final_sett", int'(final_sett), 23);
    chk("reenable_div", int'(adjusteddiv), 23);

    // Floor: impossible band keeps pulling down; divisor sticks at 1 while pulses continue.
    init      = 1'b0;
    setperiod = 8'd6;
    fmax      = 8'd2;
    fmin      = 8'd2;
    tick(4);
    push(1'b0, 1'b1, 5);
    push(1'b0, 1'b1, 4);
    push(1'b0, 1'b1, 3);
    push(1'b0, 1'b1, 2);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1);
    init = 1'b1;
    drain("floor_drain", 1000);
    chk("floor_div", int'(adjusteddiv), 1);
    init = 1'b0;
    tick(4);
    chk("floor_reload", int'(adjusteddiv), 6);
    chk("floor_final_sett", int'(final_sett), 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
